// File: rtl/pipe_bypass_stage.sv
// Operand pipeline stage: run-time source mux, then a 0..MAX_DEPTH register
// chain with a run-time selected tap; a valid bit travels with the data.
//
// Ports:
//   CLK, RST        rising-edge clock, async active-high reset
//   CE, clr         chain clock enable, synchronous clear (CE-qualified)
//   sel_src         0 = x_direct, 1 = x_cascade
//   depth           active register stages (clamped to MAX_DEPTH)
//   in_valid        qualifies the selected input
//   x_direct        direct operand
//   x_cascade       cascade operand from the neighbouring slice
//   y, y_valid      tapped operand and its valid
//   y_cascade       last physical stage, independent of depth
module pipe_bypass_stage #(
  parameter int                    DATA_WIDTH = 18,
  parameter int                    MAX_DEPTH  = 2,
  parameter int                    DEPTH_W    = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE,
  input  logic                  clr,
  input  logic                  sel_src,
  input  logic [DEPTH_W-1:0]    depth,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] x_direct,
  input  logic [DATA_WIDTH-1:0] x_cascade,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  y_valid,
  output logic [DATA_WIDTH-1:0] y_cascade
);

  localparam logic [31:0] MAXD = 32'(MAX_DEPTH);

  logic [DATA_WIDTH-1:0] s;
  logic                  sv;

  logic [DATA_WIDTH-1:0] d_q [1:MAX_DEPTH];
  logic [DATA_WIDTH-1:0] d_d [1:MAX_DEPTH];
  logic [MAX_DEPTH:1]    v_q;
  logic [MAX_DEPTH:1]    v_d;

  logic [31:0] dep32;
  logic [31:0] ed;

  assign s  = sel_src ? x_cascade : x_direct;
  assign sv = in_valid;

  // Next state of the chain; clr overrides the shift.
  always_comb begin
    d_d[1] = s;
    v_d[1] = sv;
    for (int k = 2; k <= MAX_DEPTH; k++) begin
      d_d[k] = d_q[k-1];
      v_d[k] = v_q[k-1];
    end
    if (clr) begin
      for (int k = 1; k <= MAX_DEPTH; k++) begin
        d_d[k] = RESET_VAL;
      end
      v_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 1; k <= MAX_DEPTH; k++) begin
        d_q[k] <= RESET_VAL;
      end
      v_q <= '0;
    end else if (CE) begin
      d_q <= d_d;
      v_q <= v_d;
    end
  end

  // Oversized depth clamps to the last physical stage.
  assign dep32 = 32'(depth);
  assign ed    = (dep32 > MAXD) ? MAXD : dep32;

  // Tap 0 is the combinational bypass, live even during RST.
  always_comb begin
    y       = s;
    y_valid = sv;
    for (int k = 1; k <= MAX_DEPTH; k++) begin
      if (ed == 32'(k)) begin
        y       = d_q[k];
        y_valid = v_q[k];
      end
    end
  end

  assign y_cascade = d_q[MAX_DEPTH];

endmodule

// File: tb/tb_pipe_bypass_stage.sv
// Bench for pipe_bypass_stage: directed plan plus random traffic,
// checked against a sample-history model through a scoreboard queue.
module tb_pipe_bypass_stage;

  localparam int              DW  = 18;
  localparam int              MD  = 2;
  localparam int              DPW = 2;
  localparam logic [DW-1:0]   RV  = '0;

  logic           CLK = 1'b0;
  logic           RST;
  logic           CE;
  logic           clr;
  logic           sel_src;
  logic [DPW-1:0] depth;
  logic           in_valid;
  logic [DW-1:0]  x_direct;
  logic [DW-1:0]  x_cascade;
  logic [DW-1:0]  y;
  logic           y_valid;
  logic [DW-1:0]  y_cascade;

  pipe_bypass_stage #(
    .DATA_WIDTH(DW),
    .MAX_DEPTH (MD),
    .DEPTH_W   (DPW),
    .RESET_VAL (RV)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .CE       (CE),
    .clr      (clr),
    .sel_src  (sel_src),
    .depth    (depth),
    .in_valid (in_valid),
    .x_direct (x_direct),
    .x_cascade(x_cascade),
    .y        (y),
    .y_valid  (y_valid),
    .y_cascade(y_cascade)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [DW-1:0] y;
    logic          v;
    logic [DW-1:0] c;
  } exp_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          v;
  } samp_t;

  exp_t  exp_q[$];
  // hist[0] is the most recently sampled value, hist[MD-1] the oldest.
  samp_t hist[$];

  int vectors     = 0;
  int miscompares = 0;

  function automatic void flush_hist();
    hist.delete();
    for (int i = 0; i < MD; i++)
      hist.push_back('{d: RV, v: 1'b0});
  endfunction

  task automatic step(
    input logic           rst_v,
    input logic           ce_v,
    input logic           clr_v,
    input logic           sel_v,
    input logic [DPW-1:0] dep_v,
    input logic           iv_v,
    input logic [DW-1:0]  xd_v,
    input logic [DW-1:0]  xc_v
  );
    exp_t  e;
    samp_t s;
    int    ed;
    @(posedge CLK);
    #1;
    // What the edge just did with the inputs that were held across it.
    if (!RST && CE) begin
      if (clr) begin
        flush_hist();
      end else begin
        hist.push_front('{d: (sel_src ? x_cascade : x_direct),
                          v: in_valid});
        void'(hist.pop_back());
      end
    end
    RST       = rst_v;
    CE        = ce_v;
    clr       = clr_v;
    sel_src   = sel_v;
    depth     = dep_v;
    in_valid  = iv_v;
    x_direct  = xd_v;
    x_cascade = xc_v;
    if (rst_v) flush_hist();
    s.d = sel_v ? xc_v : xd_v;
    s.v = iv_v;
    ed  = (int'(dep_v) > MD) ? MD : int'(dep_v);
    if (ed == 0) begin
      e.y = s.d;
      e.v = s.v;
    end else begin
      e.y = hist[ed-1].d;
      e.v = hist[ed-1].v;
    end
    e.c = hist[MD-1].d;
    exp_q.push_back(e);
  endtask

  // Monitor: compares mid-cycle, away from the active edge.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if ({y, y_valid, y_cascade} !== {e.y, e.v, e.c}) begin
        miscompares++;
        $display("FAIL vec%0d: y=%h v=%b yc=%h, want y=%h v=%b yc=%h",
                 vectors, y, y_valid, y_cascade, e.y, e.v, e.c);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1; CE = 1'b0; clr = 1'b0; sel_src = 1'b0;
    depth = 2'd2; in_valid = 1'b0;
    x_direct = '0; x_cascade = '0;
    flush_hist();

    // 1. reset then shift at depth 2
    step(1, 1, 0, 0, 2, 0, '0, '0);
    step(1, 1, 0, 0, 2, 0, '0, '0);
    step(0, 1, 0, 0, 2, 1, 18'h00011, '0);
    step(0, 1, 0, 0, 2, 1, 18'h00022, '0);
    step(0, 1, 0, 0, 2, 1, 18'h00033, '0);
    step(0, 1, 0, 0, 2, 0, '0, '0);
    step(0, 1, 0, 0, 2, 0, '0, '0);

    // 2. bypass, including during reset
    step(0, 1, 0, 0, 0, 1, 18'h3FFFF, '0);
    step(0, 1, 0, 0, 0, 1, 18'h00000, '0);
    step(0, 1, 0, 0, 0, 0, 18'h3FFFF, '0);
    step(1, 1, 0, 0, 0, 1, 18'h12345, '0);
    step(1, 1, 0, 0, 0, 1, 18'h3FFFF, '0);

    // 3. cascade source, clamped depth, then shrink depth
    step(0, 1, 0, 1, 3, 1, '0, 18'h2AAAA);
    step(0, 1, 0, 1, 3, 1, '0, 18'h2AAAA);
    step(0, 1, 0, 1, 3, 1, '0, 18'h15555);
    step(0, 1, 0, 1, 3, 1, '0, 18'h15555);
    step(0, 1, 0, 1, 1, 1, '0, 18'h00000);

    // 4. CE freeze, clr gated by CE
    step(0, 1, 0, 0, 2, 1, 18'h00005, '0);
    step(0, 1, 0, 0, 2, 1, 18'h00006, '0);
    step(0, 0, 0, 0, 2, 1, 18'h00100, 18'h00200);
    step(0, 0, 0, 1, 2, 0, 18'h00300, 18'h00400);
    step(0, 0, 0, 0, 2, 1, 18'h00500, 18'h00600);
    step(0, 0, 1, 0, 2, 1, 18'h00700, '0);
    step(0, 1, 1, 0, 2, 1, 18'h00800, '0);
    step(0, 1, 0, 0, 2, 1, 18'h00009, '0);
    step(0, 1, 0, 0, 1, 1, 18'h0000A, '0);

    // 5. async reset mid-stream, then clean restart
    step(0, 1, 0, 0, 2, 1, 18'h00066, '0);
    step(0, 1, 0, 0, 2, 1, 18'h00077, '0);
    step(1, 1, 0, 0, 2, 1, 18'h00088, '0);
    step(0, 1, 0, 0, 2, 1, 18'h00001, '0);
    step(0, 1, 0, 0, 2, 0, '0, '0);
    step(0, 1, 0, 0, 2, 0, '0, '0);
    step(0, 1, 0, 0, 2, 0, '0, '0);

    // 6. valid gaps at depth 2
    step(0, 1, 0, 0, 2, 1, 18'h0000A, '0);
    step(0, 1, 0, 0, 2, 0, 18'h0000B, '0);
    step(0, 1, 0, 0, 2, 1, 18'h0000C, '0);
    step(0, 1, 0, 0, 2, 1, 18'h0000D, '0);
    step(0, 1, 0, 0, 2, 0, '0, '0);
    step(0, 1, 0, 0, 2, 0, '0, '0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 19) == 0),
           1'($urandom),
           DPW'($urandom),
           1'($urandom),
           DW'($urandom),
           DW'($urandom));
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(posedge CLK);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
